// File: rtl/key_button_encoder_if.sv
// Pushbutton keycode interface: raw button inputs toward the encoder,
// keycode word, strobe and held flag back toward the key decoder.
interface key_button_encoder_if;
    logic [6:0]  btn;
    logic [15:0] keycode;
    logic        key_valid;
    logic        held;

    modport master (input btn, output keycode, key_valid, held);
    modport slave  (output btn, input keycode, key_valid, held);
endinterface

// File: rtl/key_button_encoder.sv
// Pushbutton-to-keycode encoder. Buttons are synchronised, debounced as one
// vector, priority-encoded and presented as a 16-bit USB-style keycode word.
// A key_valid strobe marks each new press (or auto-repeat).
// Optional feature macro: KEY_AUTO_REPEAT_EN builds the GAP state and the
// repeat timer. Without it a held key yields a single strobe per press.
module key_button_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned REPEAT_GAP      = 2
) (
    input logic                   Clk,
    input logic                   Reset,
    key_button_encoder_if.master  bus
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Every counter below relies on these being non-zero.
    generate
        if (DEBOUNCE_CYCLES < 1 || REPEAT_GAP < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
            $error("key_button_encoder: DEBOUNCE_CYCLES and REPEAT_* must all be >= 1");
        end
    endgenerate

    logic [6:0]      sync1, sync2;
    logic [6:0]      cand, db;
    logic [DB_W-1:0] db_cnt;
    logic [7:0]      code;

    // Two-flop synchroniser on the raw buttons.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.btn;
            sync2 <= sync1;
        end
    end

    // Shared debounce: candidate must stay unchanged DEBOUNCE_CYCLES cycles.
    // The counter parks at DEBOUNCE_CYCLES once the candidate is accepted.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cand   <= '0;
            db     <= '0;
            db_cnt <= '0;
        end else if (sync2 != cand) begin
            cand   <= sync2;
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db     <= cand;
            db_cnt <= DB_W'(DEBOUNCE_CYCLES);
        end else if (db_cnt < DB_W'(DEBOUNCE_CYCLES)) begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Lowest set index wins; code is zero only when no button is down.
    always_comb begin
        code = 8'h00;
        if      (db[0]) code = 8'h28;
        else if (db[1]) code = 8'h13;
        else if (db[2]) code = 8'h15;
        else if (db[3]) code = 8'h1A;
        else if (db[4]) code = 8'h16;
        else if (db[5]) code = 8'h04;
        else if (db[6]) code = 8'h07;
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TM_W = $clog2(TMAX + 1);
    localparam int unsigned GP_W = $clog2(REPEAT_GAP + 1);

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    logic [TM_W-1:0] timer, timer_nxt;
    logic [GP_W-1:0] gap_cnt, gap_nxt;
`else
    typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

    state_t     state, state_nxt;
    logic [7:0] cur_code, code_nxt;
    logic [7:0] kc, kc_nxt;
    logic       kv, kv_nxt;
    logic       held_r;

    // State and output registers; held tracks db in step with keycode.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cur_code <= '0;
            kc       <= '0;
            kv       <= 1'b0;
            held_r   <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
            timer    <= '0;
            gap_cnt  <= '0;
`endif
        end else begin
            state    <= state_nxt;
            cur_code <= code_nxt;
            kc       <= kc_nxt;
            kv       <= kv_nxt;
            held_r   <= |db;
`ifdef KEY_AUTO_REPEAT_EN
            timer    <= timer_nxt;
            gap_cnt  <= gap_nxt;
`endif
        end
    end

    // Next state and outputs. cur_code remembers the reported key across the
    // gap so a repeat can restore it and a real change can be recognised.
    always_comb begin
        state_nxt = state;
        code_nxt  = cur_code;
        kc_nxt    = kc;
        kv_nxt    = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
        timer_nxt = timer;
        gap_nxt   = gap_cnt;
`endif
        case (state)
            IDLE: begin
                if (db != '0) begin
                    state_nxt = HOLD;
                    code_nxt  = code;
                    kc_nxt    = code;
                    kv_nxt    = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
                    timer_nxt = TM_W'(REPEAT_DELAY);
`endif
                end
            end
            HOLD: begin
                if (db == '0) begin
                    state_nxt = IDLE;
                    code_nxt  = '0;
                    kc_nxt    = '0;
                end else if (code != cur_code) begin
                    // A change right after a strobe waits a cycle so strobes never abut.
                    if (!kv) begin
                        code_nxt  = code;
                        kc_nxt    = code;
                        kv_nxt    = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
                        timer_nxt = TM_W'(REPEAT_DELAY);
`endif
                    end
`ifdef KEY_AUTO_REPEAT_EN
                end else if (timer <= TM_W'(1)) begin
                    state_nxt = GAP;
                    kc_nxt    = '0;
                    gap_nxt   = GP_W'(REPEAT_GAP - 1);
                end else begin
                    timer_nxt = timer - TM_W'(1);
`endif
                end
            end
`ifdef KEY_AUTO_REPEAT_EN
            GAP: begin
                if (db == '0) begin
                    state_nxt = IDLE;
                    code_nxt  = '0;
                    kc_nxt    = '0;
                end else if (code != cur_code) begin
                    state_nxt = HOLD;
                    code_nxt  = code;
                    kc_nxt    = code;
                    kv_nxt    = 1'b1;
                    timer_nxt = TM_W'(REPEAT_DELAY);
                end else if (gap_cnt == '0) begin
                    state_nxt = HOLD;
                    kc_nxt    = cur_code;
                    kv_nxt    = 1'b1;
                    timer_nxt = TM_W'(REPEAT_PERIOD);
                end else begin
                    gap_nxt = gap_cnt - GP_W'(1);
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
                code_nxt  = '0;
                kc_nxt    = '0;
            end
        endcase
    end

    assign bus.keycode   = {8'h00, kc};
    assign bus.key_valid = kv;
    assign bus.held      = held_r;

endmodule

// File: tb/tb_key_button_encoder.sv
// Randomised scoreboard bench for key_button_encoder. The stimulus process
// pushes the per-cycle expected outputs of a reference model; a monitor pops
// and compares after each clock edge.
module tb_key_button_encoder;

    localparam int D  = 4;
    localparam int DL = 20;
    localparam int P  = 8;
    localparam int G  = 2;
    localparam logic [7:0] CODES [7] = '{8'h28, 8'h13, 8'h15, 8'h1A, 8'h16, 8'h04, 8'h07};

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    key_button_encoder_if kif();

    key_button_encoder #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (DL),
        .REPEAT_PERIOD   (P),
        .REPEAT_GAP      (G)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (kif)
    );

    typedef struct packed {
        logic [15:0] kc;
        logic        kv;
        logic        held;
    } exp_t;

    exp_t       exp_q [$];
    logic [6:0] hist [$];
    logic [6:0] db_m;
    logic [7:0] press_code;
    int         press_t;
    int         t = 0;
    int         errors = 0;
    int         checks = 0;

    function automatic logic [7:0] enc(input logic [6:0] v);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 6; i >= 0; i--) if (v[i]) c = CODES[i];
        return c;
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (D + 3) hist.push_back(7'h00);
        db_m       = 7'h00;
        press_code = 8'h00;
        press_t    = 0;
    endtask

    // One clock of stimulus. Expected output after the coming edge follows the
    // debounced vector as it stood before that edge; the debounced vector
    // adopts a raw value once D+1 consecutive samples, two edges old, agree.
    task automatic step(input logic [6:0] b);
        exp_t       e;
        logic [7:0] c;
        logic [6:0] w;
        logic       stable;
        int         age, r, m;
        @(negedge Clk);
        Reset   = 1'b0;
        kif.btn = b;
        t++;
        c      = enc(db_m);
        e.kc   = 16'h0000;
        e.kv   = 1'b0;
        e.held = |db_m;
        if (c == 8'h00) begin
            press_code = 8'h00;
        end else begin
            if (c != press_code) begin
                press_code = c;
                press_t    = t;
            end
            age = t - press_t;
`ifdef KEY_AUTO_REPEAT_EN
            if (age < DL) begin
                e.kc = {8'h00, c};
                e.kv = (age == 0);
            end else begin
                r = age - DL;
                if (r >= G) begin
                    m = (r - G) % (P + G);
                    if (m < P) e.kc = {8'h00, c};
                    e.kv = (m == 0);
                end
            end
`else
            r = 0;
            m = 0;
            e.kc = {8'h00, c};
            e.kv = (age == 0);
`endif
        end
        exp_q.push_back(e);
        hist.push_back(b);
        w      = hist[hist.size() - 3];
        stable = 1'b1;
        for (int k = 0; k <= D; k++) if (hist[hist.size() - 3 - k] != w) stable = 1'b0;
        if (stable) db_m = w;
        if (hist.size() > 64) void'(hist.pop_front());
    endtask

    task automatic do_reset(input int n, input logic [6:0] b);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            Reset   = 1'b1;
            kif.btn = b;
            exp_q.push_back('0);
        end
        model_reset();
    endtask

    task automatic hold(input int n, input logic [6:0] b);
        for (int i = 0; i < n; i++) step(b);
    endtask

    // Monitor: compare DUT outputs shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({kif.keycode, kif.key_valid, kif.held} !== e) begin
                    errors++;
                    $display("FAIL cycle %0d outputs: got keycode=%h key_valid=%b held=%b, need keycode=%h key_valid=%b held=%b",
                             t, kif.keycode, kif.key_valid, kif.held, e.kc, e.kv, e.held);
                end
            end
        end
    end

    initial begin
        int kind, len;
        logic [6:0] v;
        Reset   = 1'b1;
        kif.btn = 7'h7F;
        model_reset();

        // Reset with all buttons down, then release: enter (0028) wins.
        do_reset(3, 7'h7F);
        hold(12, 7'h7F);
        hold(10, 7'h00);

        // Short glitch on up is filtered; long press reports 001A.
        hold(3, 7'h08);
        hold(10, 7'h00);
        hold(10, 7'h08);
        hold(10, 7'h00);

        // Priority: left, add pause, drop pause, drop left.
        hold(10, 7'h20);
        hold(10, 7'h22);
        hold(10, 7'h20);
        hold(10, 7'h00);

        // Long hold of right (auto-repeat when built in).
        hold(60, 7'h40);
        hold(10, 7'h00);

        // Release around the first gap.
        for (int h = 19; h <= 25; h++) begin
            hold(h, 7'h40);
            hold(10, 7'h00);
        end

        // Reset while a key is held, then recover.
        hold(12, 7'h10);
        do_reset(2, 7'h10);
        hold(10, 7'h10);
        hold(8, 7'h00);

        // Random segments.
        for (int s = 0; s < 160; s++) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 14);
            case (kind)
                0, 1:    v = 7'h00;
                2, 3, 4: v = 7'(1 << $urandom_range(0, 6));
                5, 6:    v = 7'($urandom_range(0, 127));
                7: begin
                    v   = 7'(1 << $urandom_range(0, 6));
                    len = $urandom_range(25, 55);
                end
                default: v = 7'($urandom_range(1, 127));
            endcase
            if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 2), v);
            hold(len, v);
        end
        hold(12, 7'h00);

        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, need 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
